udp_rx_stream: RTL and testbench

UDP_RX_STREAM -- requirements
Module: udp_rx_stream

---
 rtl/udp_rx_stream_if.sv | 32 +++
 rtl/udp_rx_stream.sv | 243 ++++++++++++++++++++++++
 tb/tb_udp_rx_stream.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_stream_if.sv
// Stream bundle for udp_rx_stream: Ethernet words in, UDP payload words out.
// Either side is a valid/ready stream; sop/eop frame the packet.
interface udp_rx_stream_if;
  logic [31:0] rx_data;
  logic        rx_vld;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_rdy;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_empty;
  logic        out_err;
  logic        out_rdy;

  modport master (
    output rx_data, rx_vld, rx_sop, rx_eop,
    input  rx_rdy,
    input  out_data, out_vld, out_sop, out_eop,
    input  out_empty, out_err,
    output out_rdy
  );

  modport slave (
    input  rx_data, rx_vld, rx_sop, rx_eop,
    output rx_rdy,
    output out_data, out_vld, out_sop, out_eop,
    output out_empty, out_err,
    input  out_rdy
  );
endinterface

// File: rtl/udp_rx_stream.sv
// UDP receive filter: parses Ethernet/IPv4/UDP headers, streams payload.
// Define UDP_RX_STATS_EN to build the packet/drop counters.
module udp_rx_stream #(
  parameter logic [15:0] P_MIN_PAYLOAD = 16'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [47:0]          i_self_mac,
  input  logic [31:0]          i_self_ip,
  input  logic [15:0]          i_udp_port,
  udp_rx_stream_if.slave       bus,
  output logic                 o_abort,
  output logic [31:0]          o_src_ip,
  output logic [15:0]          o_src_port,
  output logic [15:0]          o_pkt_cnt,
  output logic [15:0]          o_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  widx, widx_nx;
  logic        ok, ok_nx;
  logic        mac_self, mac_self_nx;
  logic        mac_bc, mac_bc_nx;
  logic [31:0] sip, sip_nx;
  logic [15:0] sport, sport_nx;
  logic [15:0] rem, rem_nx;
  logic [1:0]  last_empty, last_empty_nx;
  logic        first, first_nx;

  logic        rdy;
  logic        take;
  logic [31:0] wd;
  logic [15:0] udp_bytes;
  logic [16:0] min_diff;
  logic [16:0] bytes_p3;
  logic        hdr_pass;
  logic        last;

  logic        load;
  logic        ld_sop;
  logic        ld_eop;
  logic        ld_err;
  logic [1:0]  ld_empty;
  logic        abort_nx;
  logic        accept;
  logic [1:0]  drop_inc;

  assign rdy = ~rst & ((state != PAYLOAD) | ~bus.out_vld | bus.out_rdy);
  assign bus.rx_rdy = rdy;
  assign take = bus.rx_vld & rdy;
  assign wd = bus.rx_data;

  // W10 carries udp_len; the 17-bit compare avoids a constant-true test
  assign udp_bytes = wd[31:16] - 16'd8;
  assign min_diff = {1'b0, udp_bytes} - {1'b0, P_MIN_PAYLOAD};
  assign bytes_p3 = {1'b0, udp_bytes} + 17'd3;
  assign hdr_pass = ok & (mac_self | mac_bc) & ~min_diff[16];
  assign last = (rem == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      widx       <= '0;
      ok         <= 1'b0;
      mac_self   <= 1'b0;
      mac_bc     <= 1'b0;
      sip        <= '0;
      sport      <= '0;
      rem        <= '0;
      last_empty <= '0;
      first      <= 1'b0;
    end else begin
      state      <= state_nx;
      widx       <= widx_nx;
      ok         <= ok_nx;
      mac_self   <= mac_self_nx;
      mac_bc     <= mac_bc_nx;
      sip        <= sip_nx;
      sport      <= sport_nx;
      rem        <= rem_nx;
      last_empty <= last_empty_nx;
      first      <= first_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    widx_nx       = widx;
    ok_nx         = ok;
    mac_self_nx   = mac_self;
    mac_bc_nx     = mac_bc;
    sip_nx        = sip;
    sport_nx      = sport;
    rem_nx        = rem;
    last_empty_nx = last_empty;
    first_nx      = first;
    load          = 1'b0;
    ld_sop        = 1'b0;
    ld_eop        = 1'b0;
    ld_err        = 1'b0;
    ld_empty      = 2'd0;
    abort_nx      = 1'b0;
    accept        = 1'b0;
    drop_inc      = 2'd0;
    if (take) begin
      if (bus.rx_sop) begin
        // any sop restarts at W0; an unfinished frame counts as dropped
        abort_nx    = (state == PAYLOAD);
        drop_inc    = 2'(state != IDLE) + 2'(bus.rx_eop);
        mac_self_nx = (wd[15:0] == i_self_mac[47:32]);
        mac_bc_nx   = (wd[15:0] == 16'hFFFF);
        ok_nx       = 1'b1;
        widx_nx     = 4'd1;
        state_nx    = bus.rx_eop ? IDLE : HDR;
      end else begin
        unique case (state)
          IDLE: ;
          HDR: begin
            widx_nx = widx + 4'd1;
            unique case (1'b1)
              (widx == 4'd1): begin
                mac_self_nx = mac_self & (wd == i_self_mac[31:0]);
                mac_bc_nx   = mac_bc & (&wd);
              end
              (widx == 4'd3): ok_nx = ok & (wd[15:0] == 16'h0800);
              (widx == 4'd4): ok_nx = ok & (wd[31:24] == 8'h45);
              (widx == 4'd6): ok_nx = ok & (wd[23:16] == 8'h11);
              (widx == 4'd7): sip_nx = wd;
              (widx == 4'd8): ok_nx = ok & (wd == i_self_ip);
              (widx == 4'd9): begin
                ok_nx    = ok & (wd[15:0] == i_udp_port);
                sport_nx = wd[31:16];
              end
              default: ;
            endcase
            if (widx == 4'd10) begin
              if (hdr_pass && (udp_bytes == 16'd0)) begin
                accept   = 1'b1;
                state_nx = IDLE;
              end else if (hdr_pass && !bus.rx_eop) begin
                accept        = 1'b1;
                state_nx      = PAYLOAD;
                rem_nx        = {1'b0, bytes_p3[16:2]};
                last_empty_nx = 2'd0 - udp_bytes[1:0];
                first_nx      = 1'b1;
              end else begin
                drop_inc = 2'd1;
                state_nx = bus.rx_eop ? IDLE : DROP;
              end
            end else if (bus.rx_eop) begin
              drop_inc = 2'd1;
              state_nx = IDLE;
            end
          end
          PAYLOAD: begin
            load     = 1'b1;
            ld_sop   = first;
            ld_eop   = last | bus.rx_eop;
            ld_err   = bus.rx_eop & ~last;
            ld_empty = last ? last_empty : 2'd0;
            first_nx = 1'b0;
            rem_nx   = rem - 16'd1;
            // trailing Ethernet padding is swallowed by IDLE
            if (last || bus.rx_eop) begin
              state_nx = IDLE;
            end
          end
          DROP: begin
            if (bus.rx_eop) begin
              state_nx = IDLE;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_vld   <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
      bus.out_empty <= 2'd0;
      bus.out_err   <= 1'b0;
      o_abort       <= 1'b0;
      o_src_ip      <= '0;
      o_src_port    <= '0;
    end else begin
      o_abort <= abort_nx;
      if (accept) begin
        o_src_ip   <= sip;
        o_src_port <= sport;
      end
      if (load) begin
        bus.out_data  <= wd;
        bus.out_vld   <= 1'b1;
        bus.out_sop   <= ld_sop;
        bus.out_eop   <= ld_eop;
        bus.out_empty <= ld_empty;
        bus.out_err   <= ld_err;
      end else if (bus.out_rdy) begin
        bus.out_vld   <= 1'b0;
        bus.out_sop   <= 1'b0;
        bus.out_eop   <= 1'b0;
        bus.out_empty <= 2'd0;
        bus.out_err   <= 1'b0;
      end
    end
  end

`ifdef UDP_RX_STATS_EN
  logic [15:0] pkt_q;
  logic [15:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      pkt_q  <= pkt_q + 16'(accept);
      drop_q <= drop_q + 16'(drop_inc);
    end
  end

  assign o_pkt_cnt  = pkt_q;
  assign o_drop_cnt = drop_q;
`else
  logic unused_stats;
  assign unused_stats = ^drop_inc;
  assign o_pkt_cnt  = 16'd0;
  assign o_drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_udp_rx_stream.sv
// Directed bench for udp_rx_stream with a payload scoreboard.
// Counter expectations follow UDP_RX_STATS_EN.
module tb_udp_rx_stream;
  localparam logic [47:0] SELF_MAC = 48'h0211_2233_4455;
  localparam logic [31:0] SELF_IP  = 32'hC0A8_0102;
  localparam logic [15:0] PORT     = 16'd4660;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  udp_rx_stream_if bus();

  udp_rx_stream dut (
    .clk        (clk),
    .rst        (rst),
    .i_self_mac (SELF_MAC),
    .i_self_ip  (SELF_IP),
    .i_udp_port (PORT),
    .bus        (bus),
    .o_abort    (abort),
    .o_src_ip   (src_ip),
    .o_src_port (src_port),
    .o_pkt_cnt  (pkt_cnt),
    .o_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_abort = 0;
  exp_t sb[$];
  logic [31:0] frm[$];

  logic [47:0] f_dmac;
  logic [15:0] f_type;
  logic [7:0]  f_ver;
  logic [7:0]  f_proto;
  logic [31:0] f_dip;
  logic [15:0] f_dport;
  logic [15:0] f_sport;
  logic [31:0] f_sip;
  logic [15:0] f_ulen;
  int          f_pad;
  int          exp_pkt = 0;
  int          exp_drop = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int v);
`ifdef UDP_RX_STATS_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  function automatic logic [7:0] pb(input int seed, input int k);
    return 8'((seed + k * 7) & 255);
  endfunction

  always @(negedge clk) begin
    if (!rst && abort) n_abort++;
    if (!rst && bus.out_vld && bus.out_rdy) begin
      exp_t e;
      n_out++;
      chk("out_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_word", {32'd0, bus.out_data, bus.out_sop,
            bus.out_eop, bus.out_empty, bus.out_err},
            {32'd0, e});
      end
    end
  end

  task automatic defaults();
    f_dmac  = SELF_MAC;
    f_type  = 16'h0800;
    f_ver   = 8'h45;
    f_proto = 8'h11;
    f_dip   = SELF_IP;
    f_dport = PORT;
    f_sport = 16'd5000;
    f_sip   = 32'h0A00_0001;
    f_ulen  = 16'd20;
    f_pad   = 0;
  endtask

  task automatic build(input int seed);
    int nb;
    int nw;
    frm.delete();
    frm.push_back({16'h0, f_dmac[47:32]});
    frm.push_back(f_dmac[31:0]);
    frm.push_back(32'h0A0B_0C0D);
    frm.push_back({16'h0E0F, f_type});
    frm.push_back({f_ver, 8'h00, f_ulen + 16'd20});
    frm.push_back(32'h1234_4000);
    frm.push_back({8'h40, f_proto, 16'h0000});
    frm.push_back(f_sip);
    frm.push_back(f_dip);
    frm.push_back({f_sport, f_dport});
    frm.push_back({f_ulen, 16'h0000});
    nb = int'(f_ulen) - 8;
    nw = (nb + f_pad + 3) / 4;
    for (int i = 0; i < nw; i++)
      frm.push_back({pb(seed, 4*i), pb(seed, 4*i+1),
                     pb(seed, 4*i+2), pb(seed, 4*i+3)});
  endtask

  task automatic push_exp(input logic [31:0] d, input bit s, input bit e,
                          input int emp, input bit er);
    exp_t x;
    x.data = d;
    x.sop = s;
    x.eop = e;
    x.empty = 2'(emp);
    x.err = er;
    sb.push_back(x);
  endtask

  task automatic expect_all();
    int nb;
    int n;
    int emp;
    nb = int'(f_ulen) - 8;
    n = (nb + 3) / 4;
    emp = (4 - (nb % 4)) % 4;
    for (int i = 0; i < n; i++)
      push_exp(frm[11+i], i == 0, i == n-1, (i == n-1) ? emp : 0, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] d, input bit s, input bit e);
    bit got;
    got = 1'b0;
    bus.rx_data = d;
    bus.rx_sop = s;
    bus.rx_eop = e;
    bus.rx_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rx_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("rx_rdy_timeout", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    bus.rx_vld = 1'b0;
    bus.rx_sop = 1'b0;
    bus.rx_eop = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit eop_last);
    for (int i = 0; i < n; i++)
      send_word(frm[i], i == 0, eop_last && (i == n-1));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_vld) break;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_pkt"}, 64'(pkt_cnt), 64'(cnt_exp(exp_pkt)));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(cnt_exp(exp_drop)));
  endtask

  initial begin
    int base;
    int ab;
    bit seen;
    logic [31:0] held;
    bus.rx_data = '0;
    bus.rx_vld = 1'b0;
    bus.rx_sop = 1'b0;
    bus.rx_eop = 1'b0;
    bus.out_rdy = 1'b1;
    defaults();

    repeat (3) @(negedge clk);
    chk("rst_vld", 64'(bus.out_vld), 64'd0);
    chk("rst_rdy", 64'(bus.rx_rdy), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_flags", 64'({bus.out_sop, bus.out_eop, bus.out_err,
        bus.out_empty, abort}), 64'd0);
    chk("rst_src", 64'({src_ip, src_port}), 64'd0);
    chk("rst_cnt", 64'({pkt_cnt, drop_cnt}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", 64'(bus.rx_rdy), 64'd1);

    // 12-byte payload, three words
    defaults();
    f_sip = 32'h0A00_0011;
    f_sport = 16'd1111;
    build(3);
    expect_all();
    base = n_out;
    send_frame(frm.size(), 1'b1);
    exp_pkt++;
    drain("t1_drain");
    chk("t1_words", 64'(n_out - base), 64'd3);
    chk("t1_src_ip", 64'(src_ip), 64'h0A00_0011);
    chk("t1_src_port", 64'(src_port), 64'd1111);
    chk_cnt("t1");

    // 7-byte payload plus 18 bytes of padding
    defaults();
    f_ulen = 16'd15;
    f_pad = 18;
    build(40);
    expect_all();
    base = n_out;
    send_frame(frm.size(), 1'b1);
    exp_pkt++;
    drain("t2_drain");
    chk("t2_words", 64'(n_out - base), 64'd2);
    chk("t2_rdy", 64'(bus.rx_rdy), 64'd1);
    chk_cnt("t2");

    // wrong destination port, then a good frame
    defaults();
    f_dport = PORT + 16'd1;
    build(77);
    base = n_out;
    send_frame(frm.size(), 1'b1);
    exp_drop++;
    drain("t3_drain");
    chk("t3_words", 64'(n_out - base), 64'd0);
    chk_cnt("t3a");
    defaults();
    f_sip = 32'h0A00_0033;
    build(90);
    expect_all();
    send_frame(frm.size(), 1'b1);
    exp_pkt++;
    drain("t3b_drain");
    chk("t3_src_ip", 64'(src_ip), 64'h0A00_0033);
    chk_cnt("t3b");

    // downstream stall of five cycles on the first payload word
    defaults();
    f_ulen = 16'd24;
    build(5);
    expect_all();
    base = n_out;
    fork
      send_frame(frm.size(), 1'b1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
          @(posedge clk);
          #1;
          if (bus.out_vld) begin
            seen = 1'b1;
            break;
          end
        end
        chk("t4_wait", 64'(seen), 64'd1);
        bus.out_rdy = 1'b0;
        held = frm[11];
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t4_hold", 64'(bus.out_data), 64'(held));
          chk("t4_rdy", 64'(bus.rx_rdy), 64'd0);
        end
        @(posedge clk);
        #1 bus.out_rdy = 1'b1;
      end
    join
    exp_pkt++;
    drain("t4_drain");
    chk("t4_words", 64'(n_out - base), 64'd4);
    chk_cnt("t4");

    // new sop after two payload words aborts the packet
    defaults();
    f_ulen = 16'd24;
    build(11);
    push_exp(frm[11], 1'b1, 1'b0, 0, 1'b0);
    push_exp(frm[12], 1'b0, 1'b0, 0, 1'b0);
    ab = n_abort;
    send_frame(13, 1'b0);
    exp_pkt++;
    defaults();
    f_sip = 32'h0A00_0055;
    f_sport = 16'd5555;
    build(60);
    expect_all();
    send_frame(frm.size(), 1'b1);
    exp_drop++;
    exp_pkt++;
    drain("t5_drain");
    chk("t5_abort", 64'(n_abort - ab), 64'd1);
    chk("t5_src", 64'({src_ip, src_port}), {16'd0, 32'h0A00_0055, 16'd5555});
    chk_cnt("t5");

    // frame cut short at W6
    defaults();
    f_sip = 32'h0A00_0066;
    build(2);
    base = n_out;
    send_frame(7, 1'b1);
    exp_drop++;
    drain("t6_drain");
    chk("t6_words", 64'(n_out - base), 64'd0);
    chk("t6_rdy", 64'(bus.rx_rdy), 64'd1);
    chk("t6_src_kept", 64'(src_ip), 64'h0A00_0055);
    chk_cnt("t6");

    // eop after two of four payload words
    defaults();
    f_ulen = 16'd24;
    build(21);
    push_exp(frm[11], 1'b1, 1'b0, 0, 1'b0);
    push_exp(frm[12], 1'b0, 1'b1, 0, 1'b1);
    send_frame(13, 1'b1);
    exp_pkt++;
    drain("t7_drain");
    chk_cnt("t7");

    // zero payload bytes, one padding word
    defaults();
    f_ulen = 16'd8;
    f_pad = 4;
    f_sip = 32'h0A00_0088;
    build(8);
    base = n_out;
    send_frame(frm.size(), 1'b1);
    exp_pkt++;
    drain("t8_drain");
    chk("t8_words", 64'(n_out - base), 64'd0);
    chk("t8_src", 64'(src_ip), 64'h0A00_0088);
    chk_cnt("t8");

    // broadcast MAC, 5-byte payload
    defaults();
    f_dmac = 48'hFFFF_FFFF_FFFF;
    f_ulen = 16'd13;
    build(99);
    expect_all();
    send_frame(frm.size(), 1'b1);
    exp_pkt++;
    drain("t9_drain");
    chk_cnt("t9");

    // wrong ethertype is dropped
    defaults();
    f_type = 16'h86DD;
    build(4);
    base = n_out;
    send_frame(frm.size(), 1'b1);
    exp_drop++;
    drain("t10_drain");
    chk("t10_words", 64'(n_out - base), 64'd0);
    chk_cnt("t10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
